// File: rtl/fetch_pkg.sv
// Shared types and sizing for the byte-serial fetch stage.
// No logic here; latency and backpressure belong to the modules that import it.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Bit offset of a byte lane inside the little-endian word.
  function automatic logic [4:0] lane_base(input logic [BYTE_IDX_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/fetch_word_assembler.sv
// 32-bit byte-lane register: one byte written per cycle into the selected lane.
// Write lands at the next edge; clear beats write; no backpressure of its own.
module fetch_word_assembler
  import fetch_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BYTE_W-1:0]     i_byte,
  input  logic [BYTE_IDX_W-1:0] i_lane,
  input  logic                  i_wr,
  input  logic                  i_clr,
  output logic [WORD_W-1:0]     o_word
);

  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;

  always_comb begin
    word_d = word_q;
    if (i_clr) begin
      word_d = '0;
    end else if (i_wr) begin
      word_d[lane_base(i_lane) +: BYTE_W] = i_byte;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign o_word = word_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC + byte-serial fetch FSM; word valid 4 cycles after start; word held stable until i_insReady.
// Optional FETCH_FAULT_EN: out-of-range fetch start raises sticky o_fault instead of wrapping.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_PC  = 0,
  parameter int          ADDR_W    = 32,
  parameter int          MEM_BYTES = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [7:0]        i_memByte,
  output logic [ADDR_W-1:0] o_memAdd,
  output logic              o_memEn,
  output logic [31:0]       o_ins,
  output logic              o_insValid,
  input  logic              i_insReady,
`ifdef FETCH_FAULT_EN
  output logic              o_fault,
`endif
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(BYTES_PER_WORD);

  fetch_state_t           state_d, state_q;
  logic [ADDR_W-1:0]      pc_d, pc_q;
  logic [BYTE_IDX_W-1:0]  idx_d, idx_q;
  logic                   asm_wr;
  logic                   asm_clr;
  logic                   start_req;
  logic [ADDR_W-1:0]      start_pc;
  logic [ADDR_W-1:0]      target_aligned;

  assign target_aligned = i_target & ~ADDR_W'(3);

`ifdef FETCH_FAULT_EN
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - BYTES_PER_WORD);
  logic fault_d, fault_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    asm_wr    = 1'b0;
    asm_clr   = 1'b0;
    start_req = 1'b0;
    start_pc  = pc_q;
`ifdef FETCH_FAULT_EN
    fault_d   = fault_q;
`endif

    unique case (state_q)
      IDLE: begin
        start_req = i_en;
      end
      FETCH: begin
        asm_wr = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_insReady) begin
          pc_d      = pc_q + PC_INC;
          start_pc  = pc_q + PC_INC;
          state_d   = IDLE;
          start_req = i_en;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides everything above, including a same-cycle HOLD transfer's pc + 4.
    if (i_redirect) begin
      pc_d      = target_aligned;
      start_pc  = target_aligned;
      idx_d     = '0;
      asm_wr    = 1'b0;
      asm_clr   = 1'b1;
      state_d   = IDLE;
      start_req = i_en;
`ifdef FETCH_FAULT_EN
      fault_d   = 1'b0;
`endif
    end

    if (start_req) begin
      idx_d = '0;
`ifdef FETCH_FAULT_EN
      if (start_pc > LAST_WORD) begin
        fault_d = 1'b1;
      end else begin
        state_d = FETCH;
      end
`else
      state_d = FETCH;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign o_fault  = fault_q;
  assign o_memAdd = pc_q + ADDR_W'(idx_q);
`else
  localparam logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(MEM_BYTES);

  assign o_memAdd = (pc_q + ADDR_W'(idx_q)) % MEM_SIZE;
`endif

  fetch_word_assembler u_asm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_byte (i_memByte),
    .i_lane (idx_q),
    .i_wr   (asm_wr),
    .i_clr  (asm_clr),
    .o_word (o_ins)
  );

  assign o_memEn    = (state_q == FETCH);
  assign o_insValid = (state_q == HOLD);
  assign o_pc       = pc_q;

endmodule
